// File: rtl/fft_pkg.sv
// fft_pkg: scheduler state encoding and default FFT sizing shared with the datapath.
package fft_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} fft_sched_state_t;
  localparam int FFT_LOG2N = 4;
  localparam int FFT_PIPE_DEPTH = 8;
endpackage

// File: rtl/fft_wb_delay.sv
// fft_wb_delay: DEPTH-stage {valid,P,Q} delay line that shifts only when ADV is high.
module fft_wb_delay #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ADV,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);
  logic [WIDTH-1:0] line [DEPTH];
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) line[i] <= '0;
    end else if (ADV) begin
      line[0] <= D;
      for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
    end
  assign Q = line[DEPTH-1];
endmodule

// File: rtl/fft_scheduler.sv
// fft_scheduler: radix-2 FFT butterfly read/twiddle/write-back sequencer.
// Optional FFT_SCHED_STALL_CNT_EN adds a 16-bit saturating HOLD-while-BUSY counter.
module fft_scheduler
  import fft_pkg::*;
#(
  parameter int LOG2N      = FFT_LOG2N,
  parameter int PIPE_DEPTH = FFT_PIPE_DEPTH
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      START,
  input  logic                      HOLD,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      BF_EN,
  output logic                      RD_VALID,
  output logic [LOG2N-1:0]          RD_ADDR_P,
  output logic [LOG2N-1:0]          RD_ADDR_Q,
  output logic [LOG2N-2:0]          TF_ADDR,
  output logic                      WR_VALID,
  output logic [LOG2N-1:0]          WR_ADDR_P,
  output logic [LOG2N-1:0]          WR_ADDR_Q,
  output logic [$clog2(LOG2N)-1:0]  STAGE
`ifdef FFT_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]               STALL_CNT
`endif
);
  localparam int SW = $clog2(LOG2N);
  localparam int CW = $clog2(PIPE_DEPTH + 1);
  localparam logic [LOG2N-2:0] K_LAST = '1;
  localparam logic [LOG2N-1:0] A_ONE = 1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [CW-1:0] D_LAST = CW'(PIPE_DEPTH - 1);

  fft_sched_state_t state, nxt;
  logic [SW-1:0] stage;
  logic [LOG2N-2:0] k, tf;
  logic [CW-1:0] dcnt;
  logic busy, issue, k_end, d_end;
  logic [LOG2N-1:0] kw, mask, p, q;
  logic [2*LOG2N:0] wb_q;

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) state <= IDLE;
    else state <= nxt;

  assign k_end = k == K_LAST;
  assign d_end = dcnt == D_LAST;

  always_comb
    case (state)
      IDLE:    nxt = START && !HOLD ? ISSUE : IDLE;
      ISSUE:   nxt = !HOLD && k_end ? DRAIN : ISSUE;
      DRAIN:   nxt = HOLD || !d_end ? DRAIN : (stage == S_LAST ? FIN : ISSUE);
      default: nxt = IDLE;
    endcase

  // k wraps to 0 naturally after N/2-1 because it is LOG2N-1 bits wide
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      stage <= '0;
      k <= '0;
      dcnt <= '0;
    end else if (!HOLD) begin
      if (state == ISSUE) k <= k + 1'b1;
      if (state == DRAIN) begin
        dcnt <= d_end ? '0 : dcnt + 1'b1;
        if (d_end) stage <= stage == S_LAST ? '0 : stage + 1'b1;
      end
    end

  // P inserts a zero at bit s of k; Q sets that bit; twiddle index is the low s bits scaled up
  assign kw   = {1'b0, k};
  assign mask = (A_ONE << stage) - 1'b1;
  assign p    = ((kw & ~mask) << 1) | (kw & mask);
  assign q    = p | (A_ONE << stage);
  assign tf   = (k & mask[LOG2N-2:0]) << (S_LAST - stage);

  assign busy  = state == ISSUE || state == DRAIN;
  assign issue = (state == ISSUE) && !HOLD;

  fft_wb_delay #(.DEPTH(PIPE_DEPTH), .WIDTH(2*LOG2N+1)) u_wb (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .ADV(!HOLD),
    .D({issue, p, q}),
    .Q(wb_q)
  );

  always_comb begin
    BUSY      = busy;
    DONE      = state == FIN;
    BF_EN     = busy && !HOLD;
    RD_VALID  = issue;
    RD_ADDR_P = state == ISSUE ? p : '0;
    RD_ADDR_Q = state == ISSUE ? q : '0;
    TF_ADDR   = state == ISSUE ? tf : '0;
    WR_VALID  = wb_q[2*LOG2N] && !HOLD;
    WR_ADDR_P = wb_q[2*LOG2N] ? wb_q[2*LOG2N-1:LOG2N] : '0;
    WR_ADDR_Q = wb_q[2*LOG2N] ? wb_q[LOG2N-1:0] : '0;
    STAGE     = busy ? stage : '0;
  end

`ifdef FFT_SCHED_STALL_CNT_EN
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) STALL_CNT <= '0;
    else if (state == IDLE && START) STALL_CNT <= '0;
    else if (busy && HOLD && STALL_CNT != 16'hFFFF) STALL_CNT <= STALL_CNT + 1'b1;
`endif
endmodule

// File: tb/tb_fft_scheduler.sv
// tb_fft_scheduler: random + directed checks of two scheduler configs against a step-count model.
module tb_fft_scheduler;
  logic CLK = 1'b0, RESET_N = 1'b0, START = 1'b0, HOLD = 1'b0;
  always #5 CLK = ~CLK;

  logic a_busy, a_done, a_bf, a_rv, a_wv;
  logic [3:0] a_rp, a_rq, a_wp, a_wq;
  logic [2:0] a_tf;
  logic [1:0] a_st;
  logic b_busy, b_done, b_bf, b_rv, b_wv;
  logic [1:0] b_rp, b_rq, b_wp, b_wq;
  logic [0:0] b_tf, b_st;
`ifdef FFT_SCHED_STALL_CNT_EN
  logic [15:0] a_sc, b_sc;
`endif

  fft_scheduler dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .HOLD(HOLD),
    .BUSY(a_busy), .DONE(a_done), .BF_EN(a_bf),
    .RD_VALID(a_rv), .RD_ADDR_P(a_rp), .RD_ADDR_Q(a_rq), .TF_ADDR(a_tf),
    .WR_VALID(a_wv), .WR_ADDR_P(a_wp), .WR_ADDR_Q(a_wq), .STAGE(a_st)
`ifdef FFT_SCHED_STALL_CNT_EN
    , .STALL_CNT(a_sc)
`endif
  );

  fft_scheduler #(.LOG2N(2), .PIPE_DEPTH(3)) dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .HOLD(HOLD),
    .BUSY(b_busy), .DONE(b_done), .BF_EN(b_bf),
    .RD_VALID(b_rv), .RD_ADDR_P(b_rp), .RD_ADDR_Q(b_rq), .TF_ADDR(b_tf),
    .WR_VALID(b_wv), .WR_ADDR_P(b_wp), .WR_ADDR_Q(b_wq), .STAGE(b_st)
`ifdef FFT_SCHED_STALL_CNT_EN
    , .STALL_CNT(b_sc)
`endif
  );

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(string n, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic int enc(int p, int q, int tf);
    return p * 256 + q * 16 + tf;
  endfunction

  function automatic void bf_addr(int l, int s, int k, output int p, output int q, output int tf);
    int span = 1 << s;
    p  = (k >> s) * 2 * span + (k & (span - 1));
    q  = p + span;
    tf = (k & (span - 1)) << (l - 1 - s);
  endfunction

  // t counts unheld busy cycles since launch; every output follows from t alone
  typedef struct packed {
    bit busy, done, bf, rv, wv;
    int rp, rq, tf, wp, wq, st;
  } exp_t;

  function automatic exp_t model(int l, int pd, bit act, int t, bit hold);
    int h = (1 << l) / 2;
    int per = h + pd;
    int u = t - pd;
    int p, q, tf;
    exp_t e;
    e = '0;
    if (act && t == l * per) e.done = 1;
    else if (act) begin
      e.busy = 1;
      e.bf = !hold;
      e.st = t / per;
      e.rv = !hold && (t % per < h);
      if (e.rv) begin bf_addr(l, t / per, t % per, p, q, tf); e.rp = p; e.rq = q; e.tf = tf; end
      e.wv = !hold && u >= 0 && (u % per < h);
      if (e.wv) begin bf_addr(l, u / per, u % per, p, q, tf); e.wp = p; e.wq = q; end
    end
    return e;
  endfunction

  localparam int TOT_A = 4 * (8 + 8), TOT_B = 2 * (2 + 3);
  bit act_a, act_b;
  int t_a, t_b, sc_a, sc_b;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      act_a <= 0; t_a <= 0; sc_a <= 0;
      act_b <= 0; t_b <= 0; sc_b <= 0;
    end else begin
      if (act_a) begin
        if (t_a == TOT_A) act_a <= 0;
        else if (!HOLD) t_a <= t_a + 1;
        else sc_a <= sc_a + 1;
      end else if (START) begin
        sc_a <= 0;
        if (!HOLD) begin act_a <= 1; t_a <= 0; end
      end
      if (act_b) begin
        if (t_b == TOT_B) act_b <= 0;
        else if (!HOLD) t_b <= t_b + 1;
        else sc_b <= sc_b + 1;
      end else if (START) begin
        sc_b <= 0;
        if (!HOLD) begin act_b <= 1; t_b <= 0; end
      end
    end

  task automatic cmp(string n, exp_t e, logic busy, logic done, logic bf, logic rv, logic wv,
                     logic [3:0] rp, logic [3:0] rq, logic [3:0] tf, logic [3:0] wp, logic [3:0] wq,
                     logic [3:0] st);
    chk({n, ".busy"}, busy, e.busy);
    chk({n, ".done"}, done, e.done);
    chk({n, ".bf_en"}, bf, e.bf);
    chk({n, ".rd_valid"}, rv, e.rv);
    chk({n, ".wr_valid"}, wv, e.wv);
    chk({n, ".stage"}, st, e.st);
    if (e.rv) begin
      chk({n, ".rd_p"}, rp, e.rp);
      chk({n, ".rd_q"}, rq, e.rq);
      chk({n, ".tf"}, tf, e.tf);
    end
    if (e.wv) begin
      chk({n, ".wr_p"}, wp, e.wp);
      chk({n, ".wr_q"}, wq, e.wq);
    end
  endtask

  always @(negedge CLK)
    if (RESET_N) begin
      cmp("a", model(4, 8, act_a, t_a, HOLD), a_busy, a_done, a_bf, a_rv, a_wv,
          a_rp, a_rq, {1'b0, a_tf}, a_wp, a_wq, {2'b0, a_st});
      cmp("b", model(2, 3, act_b, t_b, HOLD), b_busy, b_done, b_bf, b_rv, b_wv,
          {2'b0, b_rp}, {2'b0, b_rq}, {3'b0, b_tf}, {2'b0, b_wp}, {2'b0, b_wq}, {3'b0, b_st});
`ifdef FFT_SCHED_STALL_CNT_EN
      chk("a.stall_cnt", a_sc, sc_a);
      chk("b.stall_cnt", b_sc, sc_b);
`endif
    end

  int qa[$], qb[$];
  int a_dn = 0, a_dat = 0, b_dn = 0, b_dat = 0, a_wn = 0;
  always @(negedge CLK) begin
    if (a_rv) qa.push_back(enc(a_rp, a_rq, a_tf));
    if (b_rv) qb.push_back(enc(b_rp, b_rq, b_tf));
    if (a_wv) a_wn++;
    if (a_done) begin a_dn++; a_dat = cyc; end
    if (b_done) begin b_dn++; b_dat = cyc; end
  end

  int st, ia, ib, dn, wn, bdn;

  task automatic snap();
    ia = qa.size(); ib = qb.size(); dn = a_dn; wn = a_wn; bdn = b_dn;
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1;
    START = 1; st = cyc;
    @(posedge CLK); #1;
    START = 0;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) begin @(posedge CLK); #1; end
  endtask

  task automatic zero_chk(string n);
    chk({n, ".a_outs"}, {a_busy, a_done, a_bf, a_rv, a_wv, a_rp, a_rq, a_tf, a_wp, a_wq, a_st}, 0);
    chk({n, ".b_outs"}, {b_busy, b_done, b_bf, b_rv, b_wv, b_rp, b_rq, b_tf, b_wp, b_wq, b_st}, 0);
`ifdef FFT_SCHED_STALL_CNT_EN
    chk({n, ".stall_cnt"}, a_sc, 0);
`endif
  endtask

  task automatic run_chk(string n, int done_at);
    int p, q, tf;
    chk({n, ".done_count"}, a_dn - dn, 1);
    chk({n, ".done_cycle"}, a_dat - st, done_at);
    chk({n, ".writes"}, a_wn - wn, 32);
    chk({n, ".reads"}, qa.size() - ia, 32);
    if (qa.size() - ia >= 32)
      for (int i = 0; i < 32; i++) begin
        bf_addr(4, i / 8, i % 8, p, q, tf);
        chk({n, ".rd_seq"}, qa[ia+i], enc(p, q, tf));
      end
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1 zero_chk("reset");
    RESET_N = 1;

    snap();
    pulse_start();
    wait_until(st + 80);
    run_chk("basic", 65);
    if (qa.size() - ia >= 32) begin
      chk("basic.s0k0", qa[ia], enc(0, 1, 0));
      chk("basic.s0k7", qa[ia+7], enc(14, 15, 0));
      chk("basic.s1k1", qa[ia+9], enc(1, 3, 4));
      chk("basic.s3k0", qa[ia+24], enc(0, 8, 0));
      chk("basic.s3k1", qa[ia+25], enc(1, 9, 1));
      chk("basic.s3k7", qa[ia+31], enc(7, 15, 7));
    end
    chk("small.done_count", b_dn - bdn, 1);
    chk("small.done_cycle", b_dat - st, 11);
    chk("small.reads", qb.size() - ib, 4);
    if (qb.size() - ib >= 4) begin
      chk("small.s0k0", qb[ib], enc(0, 1, 0));
      chk("small.s0k1", qb[ib+1], enc(2, 3, 0));
      chk("small.s1k0", qb[ib+2], enc(0, 2, 0));
      chk("small.s1k1", qb[ib+3], enc(1, 3, 1));
    end

    snap();
    pulse_start();
    wait_until(st + 18);
    HOLD = 1;
    repeat (5) @(posedge CLK);
    #1 HOLD = 0;
    wait_until(st + 85);
    run_chk("hold", 70);
`ifdef FFT_SCHED_STALL_CNT_EN
    chk("hold.stall_cnt", a_sc, 5);
`endif

    snap();
    pulse_start();
    wait_until(st + 20);
    START = 1;
    @(posedge CLK); #1 START = 0;
    wait_until(st + 80);
    run_chk("restart_ignored", 65);

    pulse_start();
    wait_until(st + 30);
    snap();
    RESET_N = 0;
    #1 zero_chk("midreset");
    @(posedge CLK); #1;
    chk("midreset.no_done", a_dn - dn, 0);
    RESET_N = 1; START = 1; st = cyc;
    snap();
    @(posedge CLK); #1 START = 0;
    wait_until(st + 80);
    run_chk("after_reset", 65);

    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK); #1;
      HOLD = $urandom_range(3) == 0;
      START = $urandom_range(24) == 0;
      RESET_N = $urandom_range(599) != 0;
    end
    HOLD = 0; START = 0; RESET_N = 1;
    repeat (100) @(posedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_scheduler.md
FFT_SCHEDULER -- requirements
Module: fft_scheduler

Interface
REQ-001 SHALL have parameter LOG2N, default 4, log2 of FFT size N (N = 16 by default; legal range 2..10).
REQ-002 SHALL have parameter PIPE_DEPTH, default 8, cycles from read issue to write-back: 1 memory read cycle plus 7 butterfly cycles.
REQ-003 SHALL have port CLK, input, 1 bit, the single clock.
REQ-004 SHALL have port RESET_N, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port START, input, 1 bit, pulse that launches one full FFT.
REQ-006 SHALL have port HOLD, input, 1 bit, global stall.
REQ-007 SHALL have port BUSY, output, 1 bit, high from the first ISSUE cycle through the last DRAIN cycle.
REQ-008 SHALL have port DONE, output, 1 bit, one-cycle completion pulse.
REQ-009 SHALL have port BF_EN, output, 1 bit, enable for the butterfly datapath.
REQ-010 SHALL have ports RD_VALID (1 bit), RD_ADDR_P and RD_ADDR_Q (LOG2N bits each) as outputs, the operand read request.
REQ-011 SHALL have port TF_ADDR, output, LOG2N-1 bits, twiddle ROM index.
REQ-012 SHALL have ports WR_VALID (1 bit), WR_ADDR_P and WR_ADDR_Q (LOG2N bits each) as outputs, the result write-back request.
REQ-013 SHALL have port STAGE, output, clog2(LOG2N) bits, current stage index.

Function
REQ-014 SHALL implement states IDLE, ISSUE, DRAIN and FIN.
- IDLE->ISSUE on START.
- ISSUE->DRAIN after N/2 issued butterflies.
- DRAIN->ISSUE (next stage) or DRAIN->FIN (after last stage) after PIPE_DEPTH unheld cycles.
- FIN->IDLE unconditionally.
REQ-015 SHALL, in ISSUE while HOLD=0, assert RD_VALID and issue butterfly k (0..N/2-1) of stage s, one per cycle:
- span = 2^s
- P = (k>>s)*2*span + (k & (span-1))
- Q = P + span
- TF_ADDR = (k & (span-1)) << (LOG2N-1-s)
REQ-016 SHALL assert WR_VALID with the P/Q of an issued butterfly exactly PIPE_DEPTH unheld cycles after its RD_VALID, using a PIPE_DEPTH-entry {valid,P,Q} delay line.
REQ-017 SHALL make DRAIN exactly PIPE_DEPTH unheld cycles long, so that the stage's last WR_VALID occurs on the last DRAIN cycle and no stage reads before the previous stage's writes finish.
REQ-018 SHALL, while HOLD=1, freeze state, counters and delay line, and drive RD_VALID=0, WR_VALID=0 and BF_EN=0.
REQ-019 SHALL drive BF_EN = BUSY & ~HOLD.
REQ-020 SHALL ignore START when not in IDLE, and SHALL launch if START coincides with FIN->IDLE only when it is sampled in IDLE.
REQ-021 SHALL, with START sampled in cycle 0 and no HOLD, drive BUSY in cycles 1..LOG2N*(N/2+PIPE_DEPTH) and DONE in the following cycle (cycle 65 for the defaults).
REQ-022 SHALL hold STAGE at the current stage s during ISSUE/DRAIN, and at 0 in IDLE/FIN.
REQ-023 SHALL compute all address arithmetic unsigned, truncated to LOG2N bits, with no overflow possible in the legal range.

Reset
REQ-024 SHALL, on RESET_N=0, asynchronously force IDLE, stage 0 and k 0, clear all delay-line valids, and drive every output to 0.
REQ-025 SHALL, on reset mid-FFT, abandon the transform without DONE or further WR_VALID, and SHALL accept START on the first cycle after reset release.

Configuration
REQ-026 SHALL, with FFT_SCHED_STALL_CNT_EN defined, provide output STALL_CNT (16 bits) counting HOLD=1 cycles while BUSY, saturating at 0xFFFF, cleared by reset and by START in IDLE.
REQ-027 SHALL, without FFT_SCHED_STALL_CNT_EN, omit port STALL_CNT and its logic, leaving all other behaviour identical.

Structure
REQ-028 SHALL take the state encoding (fft_sched_state_t) and default LOG2N/PIPE_DEPTH constants from the shared package fft_pkg, which the FFT datapath also uses.
REQ-029 SHALL place the delay line in one sub-module, fft_wb_delay, with parameters DEPTH and WIDTH and an advance enable; the FSM and address generation stay in fft_scheduler.

Verification
REQ-030 SHALL cover: defaults, START at cycle 0, no HOLD -> stage 0 reads (0,1),(2,3)..(14,15) with TF_ADDR 0; stage 3 reads (0,8),(1,9)..(7,15) with TF_ADDR 0..7; DONE at cycle 65.
REQ-031 SHALL cover: every RD_VALID -> matching WR_VALID with identical P/Q exactly 8 cycles later; 32 writes total, none after DONE.
REQ-032 SHALL cover: HOLD high for 5 cycles during stage 1 ISSUE -> RD/WR_VALID and BF_EN low for those cycles, address sequence unchanged, DONE at cycle 70, STALL_CNT=5 when the macro is defined.
REQ-033 SHALL cover: START pulsed at cycle 20 while BUSY -> ignored, DONE still at cycle 65 and only once.
REQ-034 SHALL cover: RESET_N low at cycle 30 -> all outputs 0 immediately; START after release -> clean run, DONE 65 cycles after that START.
REQ-035 SHALL cover: LOG2N=2, PIPE_DEPTH=3 -> stage 0 reads (0,1),(2,3); stage 1 reads (0,2) TF 0 and (1,3) TF 1; DONE 11 cycles after START.
